// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the seven-segment scan driver:
//   NUM_DIGITS     - number of digits on the board display
//   AN_OFF/SEG_OFF - active-low "everything dark" values for anodes/segments
//   HEX_SEG_TABLE  - hex nibble to active-low segment pattern, seg[0]=a .. seg[6]=g
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;
  localparam seg_t                  SEG_OFF = 7'h7F;

  localparam seg_t HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg7_scan_drv_if.sv
// seg7_scan_drv_if
// Update channel between the CPU/MMIO side and the display driver.
//   upd_req  - request, held by the source until upd_ack
//   data_in  - 8 hex digits, digit i in data_in[4i+3:4i], digit 0 rightmost
//   dp_in    - decimal point per digit, 1 = lit
//   digit_en - per-digit enable, 1 = shown
//   upd_ack  - one-cycle pulse when the inputs were captured
// master = value source, slave = display driver.
interface seg7_scan_drv_if;
  import seg7_pkg::*;

  logic                    upd_req;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    upd_ack;

  modport master (output upd_req, data_in, dp_in, digit_en, input upd_ack);
  modport slave  (input upd_req, data_in, dp_in, digit_en, output upd_ack);

endinterface

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec
// Purely combinational hex nibble to active-low seven-segment pattern.
//   nibble - 4-bit hex value
//   seg    - segments a..g on seg[0]..seg[6], active-low
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit owns a slot of SCAN_CYCLES clocks; the first BLANK_CYCLES of every
// slot keep all anodes off so the previous digit cannot ghost into the next.
// New values are only taken at the frame boundary, so a frame never tears.
//   clk        - system clock
//   rst        - asynchronous reset, active-high
//   upd        - update channel (slave side): upd_req/data_in/dp_in/digit_en in, upd_ack out
//   frame_done - one-cycle pulse, the cycle after the last cycle of a frame
//   an         - anode selects, active-low
//   seg        - segments a..g, active-low
//   dp         - decimal point, active-low
// SCAN_CYCLES must be >= 2 and BLANK_CYCLES < SCAN_CYCLES.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int SCAN_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_drv_if.slave        upd,
  output logic                  frame_done,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // With no blanking configured a slot starts directly in SHOW.
  localparam logic [0:0] ST_SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [0:0]              state;
  logic [0:0]              state_nxt;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    slot_wrap;
  logic                    frame_end;
  logic                    lit;
  logic [3:0]              cur_nibble;
  seg_t                    dec_seg;

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_end  = slot_wrap && (idx == IDX_LAST);
  assign cur_nibble = sh_data[{idx, 2'b00} +: 4];
  assign lit        = (state == ST_SHOW) && sh_en[idx];

  seg7_hex_dec u_hex_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Slot counter and digit index; idx advances once per slot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // BLANK covers the first BLANK_CYCLES counts of a slot, SHOW the rest.
  always_comb begin
    state_nxt = state;
    if (slot_wrap) begin
      state_nxt = ST_SLOT_START;
    end else if (BLANK_CYCLES > 0 && cnt == BLANK_LAST) begin
      state_nxt = ST_SHOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SLOT_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow registers only change at the frame boundary; cleared on reset so
  // the display stays dark until the first update arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
    end else if (frame_end && upd.upd_req) begin
      sh_data <= upd.data_in;
      sh_dp   <= upd.dp_in;
      sh_en   <= upd.digit_en;
    end
  end

  // Registered outputs: everything reflects the previous cycle's state, which
  // keeps the pads glitch-free and gives a fixed one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
      upd.upd_ack <= 1'b0;
    end else begin
      frame_done  <= frame_end;
      upd.upd_ack <= frame_end && upd.upd_req;
      if (lit) begin
        an  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
        seg <= dec_seg;
        dp  <= ~sh_dp[idx];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv
// Self-checking bench for seg7_scan_drv with SCAN_CYCLES=8, BLANK_CYCLES=2
// (64-cycle frame). A cycle-level reference model derives every output from
// the frame position with plain arithmetic; directed spot checks cover the
// reset, update, held-request, boundary-request and mid-frame-reset cases.
module tb_seg7_scan_drv;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * SCAN;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_done;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_drv_if upd_bus ();

  seg7_scan_drv #(
    .SCAN_CYCLES  (SCAN),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd_bus),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: m_cyc is the cycle index since reset release.
  int          m_cyc   = 0;
  logic [31:0] sh_data = '0;
  logic [7:0]  sh_dp   = '0;
  logic [7:0]  sh_en   = '0;
  logic [7:0]  exp_an  = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic        exp_ack = 1'b0;
  logic        exp_fd  = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  bit chk_en    = 1'b0;
  int ack_count = 0;
  int fd_cycles [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, observed, expected, m_cyc);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] data,
                               input logic [7:0] dps, input logic [7:0] en);
    upd_bus.upd_req  = req;
    upd_bus.data_in  = data;
    upd_bus.dp_in    = dps;
    upd_bus.digit_en = en;
  endtask

  task automatic waitCycle(input int target);
    int guard = 0;
    while (m_cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (m_cyc != target) checkOutput("wait_cycle", m_cyc, target);
  endtask

  task automatic waitAck(input int limit, output int ack_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (upd_bus.upd_ack !== 1'b1 && n < limit);
    ack_cyc = m_cyc;
    if (upd_bus.upd_ack !== 1'b1) checkOutput("ack_timeout", 0, 1);
  endtask

  // Reference model: outputs of cycle k come from the frame position of
  // cycle k-1 and the shadow contents held during cycle k-1.
  always @(posedge clk or posedge rst) begin : model
    int pos;
    int d;
    int c;
    bit on;
    if (rst) begin
      m_cyc   = 0;
      sh_data = '0;
      sh_dp   = '0;
      sh_en   = '0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      exp_ack = 1'b0;
      exp_fd  = 1'b0;
    end else begin
      pos = m_cyc % FRAME;
      d   = pos / SCAN;
      c   = pos % SCAN;
      on  = (c >= BLANK) && sh_en[d];
      exp_an  = on ? ~(8'(1) << d) : 8'hFF;
      exp_seg = on ? hex_tab[(sh_data >> (4 * d)) & 32'hF] : 7'h7F;
      exp_dp  = on ? ~sh_dp[d] : 1'b1;
      exp_fd  = (pos == FRAME - 1);
      exp_ack = exp_fd && (upd_bus.upd_req === 1'b1);
      if (exp_ack) begin
        sh_data = upd_bus.data_in;
        sh_dp   = upd_bus.dp_in;
        sh_en   = upd_bus.digit_en;
      end
      m_cyc = m_cyc + 1;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("an", an, exp_an);
      checkOutput("seg", seg, exp_seg);
      checkOutput("dp", dp, exp_dp);
      checkOutput("upd_ack", upd_bus.upd_ack, exp_ack);
      checkOutput("frame_done", frame_done, exp_fd);
      checkOutput("an_onehot", ($countones(~an) <= 1), 1);
      if (upd_bus.upd_ack === 1'b1) ack_count++;
      if (frame_done === 1'b1) fd_cycles.push_back(m_cyc);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int a0;
    int a1;
    int b;
    int p;
    int n0;
    int t;

    applyStimulus(1'b0, 32'h0, 8'h00, 8'h00);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_an", an, 8'hFF);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_dp", dp, 1'b1);
    checkOutput("rst_ack", upd_bus.upd_ack, 1'b0);
    rst = 1'b0;

    // First update: two digits, dp on digit 1.
    waitCycle(10);
    applyStimulus(1'b1, 32'h0000_00F1, 8'h02, 8'h03);
    waitAck(200, a0);
    checkOutput("upd_ack_cycle", a0, 64);
    applyStimulus(1'b0, 32'h0000_00F1, 8'h02, 8'h03);
    waitCycle(70);
    checkOutput("slot0_an", an, 8'hFE);
    checkOutput("slot0_seg", seg, 7'h79);
    checkOutput("slot0_dp", dp, 1'b1);
    waitCycle(78);
    checkOutput("slot1_an", an, 8'hFD);
    checkOutput("slot1_seg", seg, 7'h0E);
    checkOutput("slot1_dp", dp, 1'b0);
    waitCycle(94);
    checkOutput("slot3_dark", an, 8'hFF);
    waitCycle(129);
    checkOutput("ack_single", ack_count, 1);
    checkOutput("fd_count", (fd_cycles.size() >= 2), 1);
    if (fd_cycles.size() >= 2) begin
      checkOutput("fd_first", fd_cycles[0], 64);
      checkOutput("fd_second", fd_cycles[1], 128);
    end

    // Full display of eights.
    applyStimulus(1'b1, 32'h8888_8888, 8'h00, 8'hFF);
    waitAck(200, a0);
    applyStimulus(1'b0, 32'h8888_8888, 8'h00, 8'hFF);
    waitCycle(a0 + 43);
    checkOutput("full_slot5_an", an, 8'hDF);
    checkOutput("full_slot5_seg", seg, 7'h00);

    // Held request across two boundaries with a data change in between.
    applyStimulus(1'b1, 32'h1234_5678, 8'h00, 8'hFF);
    waitAck(200, a0);
    applyStimulus(1'b1, 32'h9ABC_DEF0, 8'h00, 8'hFF);
    waitAck(200, a1);
    checkOutput("held_ack_gap", a1 - a0, FRAME);
    applyStimulus(1'b0, 32'h9ABC_DEF0, 8'h00, 8'hFF);
    waitCycle(a1 + 4);
    checkOutput("held_digit0_an", an, 8'hFE);
    checkOutput("held_digit0_seg", seg, 7'h40);

    // Request rising exactly on the boundary cycle.
    b = (m_cyc / FRAME + 1) * FRAME + FRAME - 1;
    waitCycle(b);
    applyStimulus(1'b1, $urandom, 8'($urandom_range(0, 255)), 8'hFF);
    waitAck(10, a0);
    checkOutput("boundary_ack_cycle", a0, b + 1);
    applyStimulus(1'b0, upd_bus.data_in, upd_bus.dp_in, upd_bus.digit_en);

    // One-cycle pulse mid-frame must be ignored.
    p = (m_cyc / FRAME + 1) * FRAME + 30;
    waitCycle(p);
    n0 = ack_count;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
    @(negedge clk);
    applyStimulus(1'b0, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
    waitCycle(p + FRAME + 40);
    checkOutput("pulse_ignored", ack_count, n0);

    // Randomized updates at random times.
    for (int i = 0; i < 12; i++) begin
      waitCycle(m_cyc + int'($urandom_range(0, 150)));
      applyStimulus(1'b1, $urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      waitAck(200, a0);
      applyStimulus(1'b0, upd_bus.data_in, upd_bus.dp_in, upd_bus.digit_en);
    end

    // Mid-frame reset while digit 4 is lit.
    applyStimulus(1'b1, $urandom, 8'h00, 8'hFF);
    waitAck(200, a0);
    applyStimulus(1'b0, upd_bus.data_in, upd_bus.dp_in, upd_bus.digit_en);
    t = a0 + 4 * SCAN + 4;
    waitCycle(t + 1);
    checkOutput("pre_rst_an", an, 8'hEF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_an", an, 8'hFF);
    checkOutput("async_rst_seg", seg, 7'h7F);
    checkOutput("async_rst_dp", dp, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = ack_count;
    waitCycle(5);
    checkOutput("post_rst_dark", an, 8'hFF);
    waitCycle(FRAME - 1);
    applyStimulus(1'b1, 32'h0000_0007, 8'h00, 8'h01);
    waitAck(10, a0);
    checkOutput("post_rst_ack_cycle", a0, FRAME);
    applyStimulus(1'b0, 32'h0000_0007, 8'h00, 8'h01);
    waitCycle(FRAME + 4);
    checkOutput("post_rst_digit0_an", an, 8'hFE);
    checkOutput("post_rst_digit0_seg", seg, 7'h78);
    checkOutput("post_rst_ack_count", ack_count - n0, 1);
    waitCycle(2 * FRAME + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
